tt_scan_reader: RTL and testbench

TT_SCAN_READER -- requirements
Module: tt_scan_reader

---
 rtl/tt_scan_reader.sv | 110 +++++++++++
 tb/tb_tt_scan_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_scan_reader.sv
// Sweeps x over 0..15 into a tri-state-driven function and captures f into a truth table.
// Latency: SETTLE cycles per vector, 16*SETTLE cycles from accepted start to done.
// No backpressure: start is ignored while a scan or its done cycle is in progress.
module tt_scan_reader #(
    parameter int unsigned SETTLE = 4,
    parameter logic [15:0] EXPECT = 16'h55F2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        f,
    output logic [3:0]  x,
    output logic        en,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_q,
    output logic        pass,
    output logic [4:0]  err_cnt
);

    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       sample;
    logic       last;
    logic       miss;
    logic [4:0] err_nxt;

    // f is only looked at on a sampling edge, so X/Z on the bus elsewhere is harmless
    assign sample  = (state == SCAN) && (cnt == 4'd0);
    assign last    = sample && (x == 4'd15);
    assign miss    = sample && (f != EXPECT[x]);
    assign err_nxt = err_cnt + {4'd0, miss};

    // State register; reset aborts any scan without producing done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs; the buffer is enabled only while scanning
    always_comb begin
        state_nxt = state;
        en        = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                en   = 1'b1;
                busy = 1'b1;
                if (last) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Vector stepping, settle countdown and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x       <= 4'd0;
            cnt     <= 4'd0;
            table_q <= 16'd0;
            pass    <= 1'b0;
            err_cnt <= 5'd0;
        end else if (state == IDLE) begin
            if (start) begin
                x       <= 4'd0;
                cnt     <= RELOAD;
                table_q <= 16'd0;
                pass    <= 1'b0;
                err_cnt <= 5'd0;
            end
        end else if (state == SCAN) begin
            if (sample) begin
                table_q[x] <= f;
                err_cnt    <= err_nxt;
                cnt        <= RELOAD;
                if (last) begin
                    x    <= 4'd0;
                    pass <= (err_nxt == 5'd0);
                end else begin
                    x <= x + 4'd1;
                end
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_tt_scan_reader.sv
// Directed bench for tt_scan_reader with a cycle-offset reference model.
// Latency checked per cycle against the model; scan lengths checked explicitly.
// No backpressure on the DUT; start is driven as pulses or held levels.
module tb_tt_scan_reader;

    localparam int          S   = 4;
    localparam logic [15:0] EXP = 16'h55F2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        f;
    logic [3:0]  x;
    logic        en, busy, done, pass;
    logic [15:0] table_q;
    logic [4:0]  err_cnt;

    logic        start1;
    logic        f1;
    logic [3:0]  x1;
    logic        en1, busy1, done1, pass1;
    logic [15:0] tq1;
    logic [4:0]  err1;

    logic [15:0] fun_tbl;
    logic [15:0] exp_v = EXP;

    int total = 0;
    int bad   = 0;
    int busy_cyc = 0;
    int done_cnt = 0;

    tt_scan_reader #(.SETTLE(S), .EXPECT(EXP)) dut (
        .clk(clk), .rst(rst), .start(start), .f(f), .x(x), .en(en), .busy(busy),
        .done(done), .table_q(table_q), .pass(pass), .err_cnt(err_cnt)
    );

    tt_scan_reader #(.SETTLE(1), .EXPECT(EXP)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .f(f1), .x(x1), .en(en1), .busy(busy1),
        .done(done1), .table_q(tq1), .pass(pass1), .err_cnt(err1)
    );

    always #5 clk = ~clk;

    // Function under test: a lookup table; the fast instance's bus floats when idle
    assign f  = fun_tbl[x];
    assign f1 = busy1 ? exp_v[x1] : 1'bz;

    // Reference model: m_k counts edges since the accepting edge (-1 = idle)
    int          m_k   = -1;
    int          m_n   = 0;
    logic [15:0] m_tbl = 16'd0;
    bit          m_fin = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k = -1; m_n = 0; m_tbl = 16'd0; m_fin = 1'b0;
        end else if (m_k < 0) begin
            if (start) begin
                m_k = 0; m_n = 0; m_tbl = fun_tbl; m_fin = 1'b0;
            end
        end else begin
            m_k++;
            if (m_k <= 16*S) m_n = m_k / S;
            if (m_k == 16*S) m_fin = 1'b1;
            if (m_k > 16*S)  m_k = -1;
        end
    end

    function automatic logic [15:0] mask_n(int n);
        logic [31:0] m;
        m = (32'd1 << n) - 32'd1;
        return (n >= 16) ? 16'hFFFF : m[15:0];
    endfunction

    logic        e_busy, e_done, e_pass;
    logic [3:0]  e_x;
    logic [15:0] e_mask, e_tbl;
    logic [4:0]  e_err;
    logic [28:0] e_vec, a_vec;

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        e_busy = (m_k >= 0) && (m_k < 16*S);
        e_done = (m_k == 16*S);
        e_x    = e_busy ? 4'(m_k / S) : 4'd0;
        e_mask = mask_n(m_n);
        e_tbl  = m_tbl & e_mask;
        e_err  = 5'($countones((m_tbl ^ exp_v) & e_mask));
        e_pass = m_fin && (e_err == 5'd0);
        e_vec  = {e_x, e_busy, e_busy, e_done, e_tbl, e_pass, e_err};
        a_vec  = {x, en, busy, done, table_q, pass, err_cnt};
        total++;
        if (a_vec !== e_vec) begin
            bad++;
            $display("FAIL cycle_model t=%0t: got x=%h en=%b busy=%b done=%b tbl=%h pass=%b err=%0d want x=%h en=%b busy=%b done=%b tbl=%h pass=%b err=%0d",
                     $time, x, en, busy, done, table_q, pass, err_cnt,
                     e_x, e_busy, e_busy, e_done, e_tbl, e_pass, e_err);
        end
        if (busy === 1'b1) busy_cyc++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic wait_done(string name);
        int n = 0;
        while (done !== 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        chk({name, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic wait_x(int v, string name);
        int n = 0;
        while (!(busy === 1'b1 && x == 4'(v)) && n < 400) begin
            tick(1);
            n++;
        end
        chk({name, "_x_reached"}, 32'(x), 32'(v));
    endtask

    // One scan from a one-cycle start pulse; checks length, single done and results
    task automatic run_scan(string name, logic [15:0] tbl, logic [15:0] w_tbl,
                            logic [4:0] w_err, logic w_pass);
        int b0, d0;
        fun_tbl = tbl;
        b0 = busy_cyc;
        d0 = done_cnt;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(name);
        chk({name, "_busy_cycles"}, 32'(busy_cyc - b0), 32'(16*S));
        tick(2);
        chk({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({name, "_table"}, 32'(table_q), 32'(w_tbl));
        chk({name, "_err_cnt"}, 32'(err_cnt), 32'(w_err));
        chk({name, "_pass"}, 32'(pass), 32'(w_pass));
        chk({name, "_en_idle"}, 32'({en, x}), 32'd0);
    endtask

    initial begin
        int b0, d0, g, n;
        rst = 1'b1;
        start = 1'b0;
        start1 = 1'b0;
        fun_tbl = EXP;
        tick(2);
        chk("reset_outputs", 32'({x, en, busy, done, table_q, pass, err_cnt}), 32'd0);
        rst = 1'b0;
        tick(2);

        run_scan("golden", 16'h55F2, 16'h55F2, 5'd0, 1'b1);
        run_scan("bit9_flip", 16'h55F2 ^ 16'h0200, 16'h57F2, 5'd1, 1'b0);
        run_scan("f_zero", 16'h0000, 16'h0000, 5'd9, 1'b0);
        run_scan("f_one", 16'hFFFF, 16'hFFFF, 5'd7, 1'b0);

        // Second start mid-scan must not disturb timing
        fun_tbl = EXP;
        b0 = busy_cyc;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_x(5, "restart");
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done("restart");
        chk("restart_busy_cycles", 32'(busy_cyc - b0), 32'(16*S));
        tick(2);
        chk("restart_table", 32'(table_q), 32'h55F2);

        // Start held high: back-to-back scans with a two-cycle gap
        start = 1'b1;
        wait_done("held_first");
        g = 0;
        tick(1);
        g++;
        while (busy !== 1'b1 && g < 10) begin
            tick(1);
            g++;
        end
        chk("held_gap_cycles", 32'(g), 32'd2);
        start = 1'b0;
        wait_done("held_second");
        tick(2);
        chk("held_second_pass", 32'(pass), 32'd1);

        // Asynchronous reset mid-scan at x=7
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_x(7, "abort");
        #2;
        rst = 1'b1;
        #1;
        chk("abort_outputs_zero", 32'({x, en, busy, done, table_q, pass, err_cnt}), 32'd0);
        d0 = done_cnt;
        tick(1);
        rst = 1'b0;
        tick(80);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_scan("after_abort", 16'h55F2, 16'h55F2, 5'd0, 1'b1);

        // Start held across reset release is taken on the first edge
        rst = 1'b1;
        start = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        start = 1'b0;
        chk("start_across_reset_busy", 32'(busy), 32'd1);
        wait_done("start_across_reset");
        tick(2);
        chk("start_across_reset_table", 32'(table_q), 32'h55F2);

        // Single-cycle settle instance with a floating bus outside the scan
        start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
        g = 0;
        n = 0;
        while (done1 !== 1'b1 && n < 100) begin
            if (busy1 === 1'b1) g++;
            chk("settle1_no_overlap", 32'(busy1 & done1), 32'd0);
            tick(1);
            n++;
        end
        chk("settle1_done_seen", 32'(done1), 32'd1);
        chk("settle1_busy_cycles", 32'(g), 32'd16);
        tick(2);
        chk("settle1_table", 32'(tq1), 32'h55F2);
        chk("settle1_pass_err", 32'({pass1, err1}), 32'h20);
        chk("settle1_en_idle", 32'({en1, x1}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
